// File: rtl/spinner_sequencer.sv
// Rotating "comet" brightness sequencer producing 16-bit PWM duty words per LED.
// Optional macro SPINNER_EXT_STEP_EN replaces the internal prescaler with an external step input.
module spinner_sequencer #(
    parameter int CHANNELS   = 4,
`ifndef SPINNER_EXT_STEP_EN
    parameter int LOG2DELAY  = 20,
`endif
    parameter int RISE_STEP  = 2,
    parameter int DECAY_STEP = 1,
    localparam int HEAD_W    = $clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    dir,
    input  logic                    frame_sync,
`ifdef SPINNER_EXT_STEP_EN
    input  logic                    step,
`endif
    output logic [16*CHANNELS-1:0]  duty_out,
    output logic                    upd,
    output logic [HEAD_W-1:0]       head_idx,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [4:0]        LEVEL_FULL = 5'd16;
    localparam logic [HEAD_W-1:0] HEAD_ONE   = 1;
    localparam logic [HEAD_W-1:0] HEAD_LAST  = HEAD_W'(CHANNELS - 1);

    state_t            state;
    logic [4:0]        level      [CHANNELS];
    logic [4:0]        level_next [CHANNELS];
    logic [HEAD_W-1:0] head_next;
    logic              tick;
    logic              all_dark;
    logic              leave_drain;

    function automatic logic [4:0] rise(input logic [4:0] l);
        int v;
        v = int'(l) + RISE_STEP;
        return (v > 16) ? LEVEL_FULL : 5'(v);
    endfunction

    function automatic logic [4:0] decay(input logic [4:0] l);
        int v;
        v = int'(l) - DECAY_STEP;
        return (v < 0) ? 5'd0 : 5'(v);
    endfunction

    // Exponential brightness: level n lights the low n bits of the duty word.
    function automatic logic [15:0] duty_of(input logic [4:0] l);
        logic [16:0] full;
        full = 17'd1 << l;
        return 16'(full - 17'd1);
    endfunction

`ifdef SPINNER_EXT_STEP_EN
    assign tick = step && (state != S_IDLE);
`else
    localparam logic [LOG2DELAY-1:0] PRE_MAX = '1;
    localparam logic [LOG2DELAY-1:0] PRE_ONE = 1;

    logic [LOG2DELAY-1:0] prescaler;

    assign tick = (state != S_IDLE) && (prescaler == PRE_MAX);
`endif

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        head_next  = head_idx;
        level_next = level;
        if (tick && state == S_RUN) begin
            if (level[head_idx] == LEVEL_FULL) begin
                if (dir)
                    head_next = (head_idx == '0) ? HEAD_LAST : head_idx - HEAD_ONE;
                else
                    head_next = (head_idx == HEAD_LAST) ? '0 : head_idx + HEAD_ONE;
            end
            for (int n = 0; n < CHANNELS; n++)
                level_next[n] = (HEAD_W'(n) == head_next) ? rise(level[n]) : decay(level[n]);
        end else if (tick && state == S_DRAIN) begin
            for (int n = 0; n < CHANNELS; n++)
                level_next[n] = decay(level[n]);
        end
        all_dark = 1'b1;
        for (int n = 0; n < CHANNELS; n++)
            if (level_next[n] != 5'd0) all_dark = 1'b0;
        leave_drain = (state == S_DRAIN) && !enable && all_dark;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            head_idx <= '0;
            duty_out <= '0;
            upd      <= 1'b0;
            busy     <= 1'b0;
            // NOTE: the level array is small register state, so it is reset like any other flop.
            for (int n = 0; n < CHANNELS; n++) level[n] <= 5'd0;
`ifndef SPINNER_EXT_STEP_EN
            prescaler <= '0;
`endif
        end else begin
            for (int n = 0; n < CHANNELS; n++) level[n] <= level_next[n];
            head_idx <= head_next;

            // Shadow load uses the levels as they stood before this cycle's tick.
            upd <= frame_sync;
            if (frame_sync)
                for (int n = 0; n < CHANNELS; n++) duty_out[16*n +: 16] <= duty_of(level[n]);

            unique case (state)
                S_IDLE: if (enable) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end
                S_RUN: if (!enable) state <= S_DRAIN;
                S_DRAIN: begin
                    if (enable) begin
                        state <= S_RUN;
                    end else if (all_dark) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifndef SPINNER_EXT_STEP_EN
            if (state == S_IDLE || leave_drain)
                prescaler <= '0;
            else
                prescaler <= prescaler + PRE_ONE;
`endif
        end
    end

endmodule

// File: tb/tb_spinner_sequencer.sv
// Self-checking bench for spinner_sequencer: directed scenarios plus randomized
// stimulus, all compared cycle by cycle against an abstract comet model.
module tb_spinner_sequencer;

    localparam int CH     = 4;
    localparam int L2D    = 2;
    localparam int RISE   = 2;
    localparam int DECAY  = 1;
    localparam int PERIOD = 1 << L2D;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          dir;
    logic          frame_sync;
    logic [16*CH-1:0] duty_out;
    logic          upd;
    logic [1:0]    head_idx;
    logic          busy;

    always #5 clk = ~clk;

    spinner_sequencer #(
        .CHANNELS   (CH),
        .LOG2DELAY  (L2D),
        .RISE_STEP  (RISE),
        .DECAY_STEP (DECAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dir        (dir),
        .frame_sync (frame_sync),
        .duty_out   (duty_out),
        .upd        (upd),
        .head_idx   (head_idx),
        .busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: mode 0 = dark/idle, 1 = spinning, 2 = draining.
    int          m_mode;
    int          m_phase;
    int          m_head;
    int          m_lvl [CH];
    logic [63:0] m_duty;
    logic        m_upd;
    logic        m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_duty();
        logic [63:0] v;
        for (int n = 0; n < CH; n++) v[16*n +: 16] = 16'((32'd1 << m_lvl[n]) - 1);
        return v;
    endfunction

    task automatic model_step();
        bit tick;
        bit dark;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_head = 0;
            foreach (m_lvl[n]) m_lvl[n] = 0;
            m_duty = '0; m_upd = 1'b0; m_busy = 1'b0;
            return;
        end
        tick  = (m_mode != 0) && (m_phase == PERIOD - 1);
        m_upd = frame_sync;
        if (frame_sync) m_duty = pack_duty();
        if (tick && m_mode == 1) begin
            if (m_lvl[m_head] == 16) m_head = (m_head + (dir ? CH - 1 : 1)) % CH;
            foreach (m_lvl[n])
                m_lvl[n] = (n == m_head) ? ((m_lvl[n] + RISE > 16) ? 16 : m_lvl[n] + RISE)
                                         : ((m_lvl[n] - DECAY < 0) ? 0 : m_lvl[n] - DECAY);
        end else if (tick && m_mode == 2) begin
            foreach (m_lvl[n]) m_lvl[n] = (m_lvl[n] - DECAY < 0) ? 0 : m_lvl[n] - DECAY;
        end
        if (m_mode != 0) m_phase = (m_phase + 1) % PERIOD;
        dark = 1;
        foreach (m_lvl[n]) if (m_lvl[n] != 0) dark = 0;
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (!enable) m_mode = 2;
            default: if (enable) m_mode = 1; else if (dark) m_mode = 0;
        endcase
        if (m_mode == 0) m_phase = 0;
        m_busy = (m_mode != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("duty_out", 64'(duty_out), m_duty);
        check("upd",      64'(upd),      64'(m_upd));
        check("head_idx", 64'(head_idx), 64'(m_head));
        check("busy",     64'(busy),     64'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; enable = 1'b0; dir = 1'b0; frame_sync = 1'b1;

        // Reset then idle.
        do_reset(2);
        run(50);
        check("idle_duty", 64'(duty_out), 64'h0);
        check("idle_upd",  64'(upd),      64'h1);
        check("idle_busy", 64'(busy),     64'h0);
        check("idle_head", 64'(head_idx), 64'h0);

        // Forward ramp: tick k lands 4k edges after entering RUN.
        enable = 1'b1; dir = 1'b0;
        run(34);
        check("fwd_t8_duty", 64'(duty_out), 64'h0000_0000_0000_FFFF);
        check("fwd_t8_head", 64'(head_idx), 64'h0);
        run(4);
        check("fwd_t9_duty", 64'(duty_out), 64'h0000_0000_0003_7FFF);
        check("fwd_t9_head", 64'(head_idx), 64'h1);
        guard = 0;
        while (head_idx != 2'd3 && guard < 400) begin cycle(); guard++; end
        check("fwd_reach3", 64'(head_idx), 64'h3);
        guard = 0;
        while (head_idx != 2'd0 && guard < 400) begin cycle(); guard++; end
        check("fwd_wrap0", 64'(head_idx), 64'h0);

        // Reverse wrap from reset.
        do_reset(2);
        dir = 1'b1;
        run(38);
        check("rev_t9_duty", 64'(duty_out), 64'h0003_0000_0000_7FFF);
        check("rev_t9_head", 64'(head_idx), 64'h3);

        // Drain from full ch0: sixteen ticks to dark, first drain tick 3 edges after the drop.
        do_reset(2);
        dir = 1'b0;
        run(34);
        check("drain_start", 64'(duty_out), 64'h0000_0000_0000_FFFF);
        enable = 1'b0;
        run(62);
        check("drain_busy", 64'(busy), 64'h1);
        run(1);
        check("drain_idle", 64'(busy), 64'h0);
        check("drain_last", 64'(duty_out), 64'h0000_0000_0000_0001);
        run(1);
        check("drain_dark", 64'(duty_out), 64'h0);

        // Frame gating: one strobe every 100 cycles.
        enable = 1'b1;
        for (int p = 0; p < 4; p++) begin
            frame_sync = 1'b1;
            cycle();
            frame_sync = 1'b0;
            run(99);
        end
        frame_sync = 1'b1;

        // Reset mid-run once ch1 shows 0x00FF.
        do_reset(2);
        guard = 0;
        while (duty_out[31:16] != 16'h00FF && guard < 400) begin cycle(); guard++; end
        check("mid_reach_ff", 64'(duty_out[31:16]), 64'h00FF);
        do_reset(1);
        check("mid_duty", 64'(duty_out), 64'h0);
        check("mid_head", 64'(head_idx), 64'h0);
        check("mid_busy", 64'(busy),     64'h0);
        run(34);
        check("mid_restart", 64'(duty_out), 64'h0000_0000_0000_FFFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) dir = ~dir;
            frame_sync = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
